// File: rtl/dbg_host_pkg.sv
// Shared types and constants for the debug host link: commands, opcode bytes, FSM states.
package dbg_host_pkg;

  typedef enum logic [1:0] {
    CMD_RESET = 2'd0,
    CMD_LOAD  = 2'd1,
    CMD_STEP  = 2'd2,
    CMD_RUN   = 2'd3
  } cmd_e;

  localparam logic [7:0] OP_RESET = 8'h52;
  localparam logic [7:0] OP_LOAD  = 8'h4C;
  localparam logic [7:0] OP_STEP  = 8'h53;
  localparam logic [7:0] OP_RUN   = 8'h47;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_START,
    ST_TX_WAIT,
    ST_RX_WAIT,
    ST_DONE,
    ST_TOUT
  } state_e;

  localparam int BYTES_PER_WORD = 4;

  function automatic logic [7:0] opcode_of(input cmd_e c);
    case (c)
      CMD_RESET: return OP_RESET;
      CMD_LOAD:  return OP_LOAD;
      CMD_STEP:  return OP_STEP;
      default:   return OP_RUN;
    endcase
  endfunction

endpackage

// File: rtl/dbg_host_word_asm.sv
// Reassembles the received dump byte stream (LSB first) into words and flags the last word of a frame.
module dbg_host_word_asm
  import dbg_host_pkg::*;
#(
  parameter int NBITS       = 32,
  parameter int N_RSP_WORDS = 66
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_byte_valid,
  input  logic [7:0]       i_byte,
  output logic [NBITS-1:0] o_rsp_word,
  output logic             o_rsp_valid,
  output logic             o_rsp_last,
  output logic             o_last_byte
);

  localparam int CW = (N_RSP_WORDS > 1) ? $clog2(N_RSP_WORDS) : 1;

  logic [1:0]       r_idx;
  logic [CW-1:0]    r_cnt;
  logic [NBITS-9:0] r_buf;
  logic             w_word_done;

  assign w_word_done = i_byte_valid && (r_idx == 2'(BYTES_PER_WORD - 1));
  assign o_last_byte = w_word_done && (r_cnt == CW'(N_RSP_WORDS - 1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_buf       <= '0;
      o_rsp_word  <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_last  <= 1'b0;
    end else begin
      o_rsp_valid <= 1'b0;
      o_rsp_last  <= 1'b0;
      if (i_clr) begin
        r_idx <= '0;
        r_cnt <= '0;
      end else if (w_word_done) begin
        o_rsp_word  <= {i_byte, r_buf};
        o_rsp_valid <= 1'b1;
        o_rsp_last  <= o_last_byte;
        r_idx       <= '0;
        // the frame ends on the last word, so the counter never needs to wrap
        if (!o_last_byte) r_cnt <= r_cnt + CW'(1);
      end else if (i_byte_valid) begin
        case (r_idx)
          2'd0:    r_buf[7:0]   <= i_byte;
          2'd1:    r_buf[15:8]  <= i_byte;
          default: r_buf[23:16] <= i_byte;
        endcase
        r_idx <= r_idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/dbg_host_link.sv
// Host side of the MIPS debug link: word commands -> UART opcode/data bytes, dump bytes -> words.
// Optional DBG_HOST_CHECKSUM_EN: trailing XOR checksum byte per frame, reported on o_chk_err.
//   state    | meaning
//   IDLE     | ready for a command
//   TX_START | one-cycle transmit start pulse
//   TX_WAIT  | byte on the wire, waiting for sent
//   RX_WAIT  | collecting dump bytes, inter-byte timer running
//   DONE     | frame complete, one cycle
//   TOUT     | inter-byte timeout, one cycle
module dbg_host_link
  import dbg_host_pkg::*;
#(
  parameter int NBITS          = 32,
  parameter int N_RSP_WORDS    = 66,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  input  logic [NBITS-1:0] i_cmd_word,
  output logic             o_cmd_ready,
  output logic [7:0]       o_uart_data,
  output logic             o_uart_send_data,
  input  logic             i_uart_data_sent,
  input  logic [7:0]       i_uart_data,
  input  logic             i_uart_data_received,
  output logic             o_rsp_valid,
  output logic [NBITS-1:0] o_rsp_word,
  output logic             o_rsp_last,
  output logic             o_busy,
`ifdef DBG_HOST_CHECKSUM_EN
  output logic             o_chk_err,
`endif
  output logic             o_timeout
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

  state_e           r_state;
  cmd_e             r_cmd;
  logic [NBITS-1:0] r_word;
  logic [2:0]       r_tx_idx;
  logic [7:0]       r_uart_data;
  logic             r_send;
  logic [TW-1:0]    r_tmr;
  logic             r_timeout;
  logic [7:0]       w_load_byte;
  logic             w_rx;
  logic             w_accept;
  logic             w_byte_valid;
  logic             w_last_byte;
  logic             w_frame_end;
  logic             w_asm_clr;

  assign o_cmd_ready      = (r_state == ST_IDLE);
  assign o_busy           = (r_state != ST_IDLE);
  assign o_uart_data      = r_uart_data;
  assign o_uart_send_data = r_send;
  assign o_timeout        = r_timeout;
  assign w_accept         = i_cmd_valid && (r_state == ST_IDLE);
  assign w_rx             = i_uart_data_received && (r_state == ST_RX_WAIT);
  assign w_asm_clr        = (r_state != ST_RX_WAIT);

  always_comb begin
    case (r_tx_idx)
      3'd0:    w_load_byte = r_word[7:0];
      3'd1:    w_load_byte = r_word[15:8];
      3'd2:    w_load_byte = r_word[23:16];
      default: w_load_byte = r_word[31:24];
    endcase
  end

`ifdef DBG_HOST_CHECKSUM_EN
  logic       r_chk_phase;
  logic       r_chk_bad;
  logic       r_chk_err;
  logic [7:0] r_chk_acc;

  assign w_byte_valid = w_rx && !r_chk_phase;
  assign w_frame_end  = w_rx && r_chk_phase;
  assign o_chk_err    = r_chk_err;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_chk_phase <= 1'b0;
      r_chk_bad   <= 1'b0;
      r_chk_err   <= 1'b0;
      r_chk_acc   <= '0;
    end else begin
      if (w_accept) r_chk_err <= 1'b0;
      if (r_state != ST_RX_WAIT) begin
        r_chk_phase <= 1'b0;
        r_chk_acc   <= '0;
      end else if (w_rx) begin
        if (r_chk_phase) begin
          r_chk_bad <= (i_uart_data != r_chk_acc);
        end else begin
          r_chk_acc <= r_chk_acc ^ i_uart_data;
          if (w_last_byte) r_chk_phase <= 1'b1;
        end
      end
      if ((r_state == ST_DONE) && r_chk_bad) r_chk_err <= 1'b1;
    end
  end
`else
  assign w_byte_valid = w_rx;
  assign w_frame_end  = w_last_byte;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= ST_IDLE;
      r_cmd       <= CMD_RESET;
      r_word      <= '0;
      r_tx_idx    <= '0;
      r_uart_data <= '0;
      r_send      <= 1'b0;
      r_tmr       <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_send <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cmd       <= cmd_e'(i_cmd);
            r_word      <= i_cmd_word;
            r_tx_idx    <= '0;
            r_uart_data <= opcode_of(cmd_e'(i_cmd));
            r_send      <= 1'b1;
            r_timeout   <= 1'b0;
            r_state     <= ST_TX_START;
          end
        end
        ST_TX_START: r_state <= ST_TX_WAIT;
        ST_TX_WAIT: begin
          if (i_uart_data_sent) begin
            if ((r_cmd == CMD_LOAD) && (r_tx_idx != 3'd4)) begin
              r_tx_idx    <= r_tx_idx + 3'd1;
              r_uart_data <= w_load_byte;
              r_send      <= 1'b1;
              r_state     <= ST_TX_START;
            end else if ((r_cmd == CMD_STEP) || (r_cmd == CMD_RUN)) begin
              r_tmr   <= TMR_LOAD;
              r_state <= ST_RX_WAIT;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_RX_WAIT: begin
          // down-counter reloads on every byte; terminal count means the link went silent
          if (w_frame_end) begin
            r_state <= ST_DONE;
          end else if (i_uart_data_received) begin
            r_tmr <= TMR_LOAD;
          end else if (r_tmr == '0) begin
            r_timeout <= 1'b1;
            r_state   <= ST_TOUT;
          end else begin
            r_tmr <= r_tmr - TW'(1);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        ST_TOUT: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  dbg_host_word_asm #(
    .NBITS       (NBITS),
    .N_RSP_WORDS (N_RSP_WORDS)
  ) u_word_asm (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clr        (w_asm_clr),
    .i_byte_valid (w_byte_valid),
    .i_byte       (i_uart_data),
    .o_rsp_word   (o_rsp_word),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_last   (o_rsp_last),
    .o_last_byte  (w_last_byte)
  );

endmodule

// File: tb/tb_dbg_host_link.sv
// Directed bench for dbg_host_link with a tx-done model and byte-level rx stimulus.
module tb_dbg_host_link;
  import dbg_host_pkg::*;

  localparam int N_WORDS = 66;
  localparam int TOUT    = 100;

  logic        i_clk;
  logic        i_rst;
  logic        i_cmd_valid;
  logic [1:0]  i_cmd;
  logic [31:0] i_cmd_word;
  logic        o_cmd_ready;
  logic [7:0]  o_uart_data;
  logic        o_uart_send_data;
  logic        i_uart_data_sent = 1'b0;
  logic [7:0]  i_uart_data;
  logic        i_uart_data_received;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_word;
  logic        o_rsp_last;
  logic        o_busy;
  logic        o_timeout;
`ifdef DBG_HOST_CHECKSUM_EN
  logic        o_chk_err;
`endif

  dbg_host_link #(
    .NBITS          (32),
    .N_RSP_WORDS    (N_WORDS),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .i_clk                (i_clk),
    .i_rst                (i_rst),
    .i_cmd_valid          (i_cmd_valid),
    .i_cmd                (i_cmd),
    .i_cmd_word           (i_cmd_word),
    .o_cmd_ready          (o_cmd_ready),
    .o_uart_data          (o_uart_data),
    .o_uart_send_data     (o_uart_send_data),
    .i_uart_data_sent     (i_uart_data_sent),
    .i_uart_data          (i_uart_data),
    .i_uart_data_received (i_uart_data_received),
    .o_rsp_valid          (o_rsp_valid),
    .o_rsp_word           (o_rsp_word),
    .o_rsp_last           (o_rsp_last),
    .o_busy               (o_busy),
`ifdef DBG_HOST_CHECKSUM_EN
    .o_chk_err            (o_chk_err),
`endif
    .o_timeout            (o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  sent_q[$];
  logic [31:0] rsp_q[$];
  int          n_last   = 0;
  int          last_pos = -1;
  int          hold_err = 0;
  int          tx_delay = 0;
  logic [7:0]  tx_byte  = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // tx completion arrives 10 cycles after each send pulse; data must stay put meanwhile
  always @(negedge i_clk) begin
    i_uart_data_sent = 1'b0;
    if (o_uart_send_data) begin
      sent_q.push_back(o_uart_data);
      tx_byte  = o_uart_data;
      tx_delay = 10;
    end else if (tx_delay > 0) begin
      if (o_uart_data !== tx_byte) hold_err++;
      tx_delay--;
      if (tx_delay == 0) i_uart_data_sent = 1'b1;
    end
    if (o_rsp_valid) begin
      rsp_q.push_back(o_rsp_word);
      if (o_rsp_last) begin
        n_last++;
        last_pos = rsp_q.size() - 1;
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clr_mon();
    sent_q.delete();
    rsp_q.delete();
    n_last   = 0;
    last_pos = -1;
    hold_err = 0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!o_cmd_ready && n < 500) begin
      tick();
      n++;
    end
    check(tag, 32'(o_cmd_ready), 32'd1);
  endtask

  task automatic issue(input logic [1:0] c, input logic [31:0] w);
    wait_ready("rdy_before_cmd");
    i_cmd_valid = 1'b1;
    i_cmd       = c;
    i_cmd_word  = w;
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    tick();
    i_uart_data          = b;
    i_uart_data_received = 1'b1;
    tick();
    i_uart_data_received = 1'b0;
  endtask

  // word k = k, LSB first; optional checksum byte follows the last word
  task automatic feed_frame(input int nbytes, input logic bad_chk);
    logic [7:0] x;
    logic [7:0] v;
    x = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      v = (i % 4 == 0) ? 8'(i / 4) : 8'h00;
      x ^= v;
      rx_byte(v);
    end
`ifdef DBG_HOST_CHECKSUM_EN
    if (nbytes == 4 * N_WORDS) rx_byte(bad_chk ? ~x : x);
`else
    if (bad_chk && nbytes < 0) rx_byte(x);
`endif
  endtask

  task automatic check_frame(input string tag);
    int errs = 0;
    check({tag, "_count"}, 32'(rsp_q.size()), 32'(N_WORDS));
    if (rsp_q.size() == N_WORDS)
      for (int k = 0; k < N_WORDS; k++) if (rsp_q[k] !== 32'(k)) errs++;
    check({tag, "_word_errs"}, 32'(errs), 32'd0);
    check({tag, "_n_last"}, 32'(n_last), 32'd1);
    check({tag, "_last_pos"}, 32'(last_pos), 32'(N_WORDS - 1));
  endtask

  task automatic step_frame(input string tag, input logic bad_chk);
    clr_mon();
    issue(CMD_STEP, 32'h0);
    repeat (20) tick();
    feed_frame(4 * N_WORDS, bad_chk);
    check({tag, "_rdy_in_done"}, 32'(o_cmd_ready), 32'd0);
    tick();
    check({tag, "_rdy_after_2"}, 32'(o_cmd_ready), 32'd1);
    check_frame(tag);
    check({tag, "_sends"}, 32'(sent_q.size()), 32'd1);
    if (sent_q.size() > 0) check({tag, "_opcode"}, 32'(sent_q[0]), 32'h53);
  endtask

  initial begin
    logic [7:0] exp_load[5];
    exp_load[0] = 8'h4C; exp_load[1] = 8'h78; exp_load[2] = 8'h56;
    exp_load[3] = 8'h34; exp_load[4] = 8'h12;

    i_rst = 1'b0; i_cmd_valid = 1'b0; i_cmd = 2'd0; i_cmd_word = '0;
    i_uart_data = 8'h00; i_uart_data_received = 1'b0;
    repeat (3) tick();
    check("rst_ready", 32'(o_cmd_ready), 32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_send", 32'(o_uart_send_data), 32'd0);
    check("rst_udata", 32'(o_uart_data), 32'd0);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_rsp_word", o_rsp_word, 32'd0);
    check("rst_rsp_last", 32'(o_rsp_last), 32'd0);
    check("rst_timeout", 32'(o_timeout), 32'd0);
    i_rst = 1'b1;
    tick();

    // LOAD_WORD: five bytes, no response
    clr_mon();
    issue(CMD_LOAD, 32'h12345678);
    check("load_busy", 32'(o_busy), 32'd1);
    wait_ready("load_return");
    check("load_sends", 32'(sent_q.size()), 32'd5);
    if (sent_q.size() == 5)
      for (int i = 0; i < 5; i++) check($sformatf("load_byte%0d", i), 32'(sent_q[i]), 32'(exp_load[i]));
    check("load_hold", 32'(hold_err), 32'd0);
    check("load_no_rsp", 32'(rsp_q.size()), 32'd0);

    // stray rx in IDLE, then STEP with cmd_valid held while waiting
    clr_mon();
    rx_byte(8'hAA);
    repeat (3) tick();
    check("stray_rx_dropped", 32'(rsp_q.size()), 32'd0);
    clr_mon();
    issue(CMD_STEP, 32'h0);
    repeat (20) tick();
    i_cmd_valid = 1'b1; i_cmd = CMD_LOAD; i_cmd_word = 32'hDEADBEEF;
    repeat (3) tick();
    i_cmd_valid = 1'b0;
    feed_frame(4 * N_WORDS, 1'b0);
    check("step_rdy_in_done", 32'(o_cmd_ready), 32'd0);
    tick();
    check("step_rdy_after_2", 32'(o_cmd_ready), 32'd1);
    check_frame("step");
    check("step_sends", 32'(sent_q.size()), 32'd1);
    if (sent_q.size() > 0) check("step_opcode", 32'(sent_q[0]), 32'h53);
`ifdef DBG_HOST_CHECKSUM_EN
    check("chk_good", 32'(o_chk_err), 32'd0);
    step_frame("chkbad", 1'b1);
    check("chk_bad", 32'(o_chk_err), 32'd1);
`endif

    // RUN then silence: one word, timeout after exactly TOUT idle cycles
    clr_mon();
    issue(CMD_RUN, 32'h0);
`ifdef DBG_HOST_CHECKSUM_EN
    check("chk_cleared", 32'(o_chk_err), 32'd0);
`endif
    repeat (20) tick();
    for (int i = 0; i < 7; i++) rx_byte(8'(8'h11 + i));
    repeat (TOUT - 1) tick();
    check("tout_not_yet", 32'(o_timeout), 32'd0);
    tick();
    check("tout_set", 32'(o_timeout), 32'd1);
    check("tout_words", 32'(rsp_q.size()), 32'd1);
    if (rsp_q.size() > 0) check("tout_word0", rsp_q[0], 32'h14131211);
    check("tout_no_last", 32'(n_last), 32'd0);
    check("run_opcode", 32'(sent_q[0]), 32'h47);
    clr_mon();
    issue(CMD_RESET, 32'h0);
    check("tout_cleared", 32'(o_timeout), 32'd0);
    wait_ready("reset_cmd_return");
    check("reset_sends", 32'(sent_q.size()), 32'd1);
    if (sent_q.size() > 0) check("reset_opcode", 32'(sent_q[0]), 32'h52);
    check("reset_cmd_no_rsp", 32'(rsp_q.size()), 32'd0);

    // async reset mid-frame, then a fresh frame
    clr_mon();
    issue(CMD_STEP, 32'h0);
    repeat (20) tick();
    feed_frame(130, 1'b0);
    check("pre_rst_words", 32'(rsp_q.size()), 32'd32);
    i_rst = 1'b0;
    #1;
    check("midrst_ready", 32'(o_cmd_ready), 32'd1);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("midrst_rsp_word", o_rsp_word, 32'd0);
    repeat (2) tick();
    i_rst = 1'b1;
    clr_mon();
    repeat (5) tick();
    check("midrst_no_rsp", 32'(rsp_q.size()), 32'd0);
    step_frame("after_rst", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dbg_host_link.md
Name: dbg_host_link

Overview:
Host-side counterpart of the MIPS debug unit. It sits behind a UART byte interface on the host or tester FPGA and turns word-level commands into the debug byte protocol. Commands are LOAD_WORD, STEP, RUN and RESET. After STEP or RUN it reassembles the returned dump byte stream into 32-bit words.

Parameters:
NBITS, 32, data/instruction word width (must be 32; byte assembly assumes 4 bytes per word).
N_RSP_WORDS, 66, words per dump frame: PC, cycle count, 32 GPRs, 32 memory words.
TIMEOUT_CYCLES, 1000000, idle clocks allowed between received bytes before abort.

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-low reset
i_cmd_valid  in  1  command request
i_cmd  in  2  0=RESET, 1=LOAD_WORD, 2=STEP, 3=RUN
i_cmd_word  in  NBITS  instruction word for LOAD_WORD
o_cmd_ready  out  1  high only in IDLE
o_uart_data  out  8  byte to transmit
o_uart_send_data  out  1  one-cycle transmit start pulse
i_uart_data_sent  in  1  one-cycle pulse: tx byte finished
i_uart_data  in  8  received byte
i_uart_data_received  in  1  one-cycle pulse: rx byte valid
o_rsp_valid  out  1  one-cycle pulse, response word valid
o_rsp_word  out  NBITS  assembled response word
o_rsp_last  out  1  qualifies the final word of a frame
o_busy  out  1  state != IDLE
o_timeout  out  1  sticky; cleared by the next accepted command

Behaviour:
- Reset (i_rst=0, async): state IDLE; all outputs 0 except o_cmd_ready=1; byte, word and timeout counters cleared. Reset mid-frame abandons the frame with no further o_rsp_valid.
- Opcode bytes: RESET=0x52, LOAD_WORD=0x4C, STEP=0x53, RUN=0x47.
- Command accept: i_cmd_valid & o_cmd_ready. i_cmd and i_cmd_word are latched that cycle. i_cmd_valid while busy is ignored.
- States: IDLE -> TX_START -> TX_WAIT -> (TX_START for the next byte | RX_WAIT | IDLE).
- RX_WAIT -> (RX_WAIT | DONE | TOUT). DONE -> IDLE. TOUT -> IDLE.
- TX_START: drive o_uart_data and pulse o_uart_send_data for exactly 1 cycle. Go to TX_WAIT.
- TX_WAIT: o_uart_data is held stable. On i_uart_data_sent, advance to the next byte.
- LOAD_WORD sends 5 bytes: opcode, then i_cmd_word LSB-first. Returns to IDLE after the last sent pulse, with no response.
- RESET sends 1 byte and returns to IDLE.
- STEP and RUN send 1 byte, then enter RX_WAIT.
- RX_WAIT assembly:
  - each i_uart_data_received shifts the byte into bits [byte_idx*8 +: 8], byte_idx 0..3.
  - at byte_idx=3, pulse o_rsp_valid with the full word; o_rsp_word holds until the next word.
  - o_rsp_last=1 together with word N_RSP_WORDS-1, then go to DONE.
- DONE lasts 1 cycle, then IDLE; o_cmd_ready returns the cycle after DONE.
- Rx pulses seen outside RX_WAIT are dropped.
- Timeout: the counter clears on each rx pulse and on RX_WAIT entry. Reaching TIMEOUT_CYCLES-1 sets o_timeout and moves to TOUT then IDLE. A partial word is discarded and no o_rsp_last is issued.
- Simultaneous i_uart_data_sent and i_uart_data_received: each is handled in its own state; a pulse not matching the current state is dropped.
- Word counter width: clog2(N_RSP_WORDS); no wrap, because the frame ends at the last word.

Optional Feature:
DBG_HOST_CHECKSUM_EN:
- Defined:
  - the frame carries one extra byte after the last word: XOR of all frame bytes.
  - new output o_chk_err (1 bit): sticky, set in DONE on mismatch, cleared on command accept.
  - o_rsp_last still qualifies the last word.
  - DONE is entered after the checksum byte.
- Undefined: no checksum byte is expected, and o_chk_err is absent.

Decomposition:
- Package dbg_host_pkg holds:
  - command enum: CMD_RESET, CMD_LOAD, CMD_STEP, CMD_RUN.
  - opcode byte localparams.
  - state enum.
  - BYTES_PER_WORD=4.
- One natural sub-module, dbg_host_word_asm: rx byte-to-word shifter, byte_idx, o_rsp_valid and o_rsp_last generation.

Test Plan:
- LOAD_WORD 0x12345678; tx model returns sent 10 cycles after each pulse -> bytes 0x4C,0x78,0x56,0x34,0x12 in order; exactly 5 send pulses; back to IDLE; no o_rsp_valid.
- STEP, then feed 264 bytes (word k = k) -> 66 o_rsp_valid pulses with words 0..65; o_rsp_last only on word 65; o_cmd_ready 2 cycles after the last byte.
- RUN, 7 bytes, then silence with TIMEOUT_CYCLES=100 -> o_timeout=1 after 100 idle cycles; only 1 word emitted; next command clears o_timeout.
- i_cmd_valid while STEP is waiting, plus a stray rx pulse in IDLE -> both ignored; the frame result is unchanged.
- Reset asserted after 130 rx bytes -> outputs at reset values within the same cycle; a fresh STEP frame completes correctly.
- DBG_HOST_CHECKSUM_EN: frame with a corrupted checksum byte -> all 66 words delivered and o_chk_err=1; a correct checksum -> o_chk_err=0.
